dma_controller_mc: RTL and testbench

- Parametrised multi-channel DMA engine; successor to the fixed 8-channel controller. Sits on the peripheral register bus as a slave and on the system memory bus as a single master.
- Adds per-channel address-increment control, peripheral-request pacing, bounded bursts with round-robin re-arbitration, abort, and a write-1-to-clear done/IRQ status register.

---
 rtl/dma_mc_pkg.sv | 27 ++
 rtl/dma_rr_arbiter.sv | 28 ++
 rtl/dma_controller_mc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dma_controller_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mc_pkg.sv
// Shared types and constants for the multi-channel DMA controller.
// State encoding, CTRL bit positions and register offsets.
package dma_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ADV  = 2'd3
  } dma_state_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_SINC  = 2;
  localparam int CTRL_DINC  = 3;
  localparam int CTRL_PACED = 4;
  localparam int CTRL_ABORT = 5;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int GREG_STATUS = 0;
  localparam int GREG_BUSY   = 1;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel after `last`.
// Ports: eligible vector, last grant in; grant index, grant_valid out.
module dma_rr_arbiter #(
  parameter  int NUM_CH = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   grant,
  output logic              grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!grant_valid && eligible[idx]) begin
        grant       = CH_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_controller_mc.sv
// Multi-channel DMA engine: register-bus slave plus one memory-bus master.
// Ports: clk/rst, reg_* slave bus, mem_* master bus, dreq pacing, dma_irq.
import dma_mc_pkg::*;

module dma_controller_mc #(
  parameter  int NUM_CH    = 8,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int CNT_W     = 16,
  parameter  int BURST_LEN = 4,
  localparam int RA_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_en,
  input  logic              reg_we,
  input  logic [RA_W-1:0]   reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [NUM_CH-1:0] dreq,
  output logic              dma_irq
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int GW   = RA_W - 1;
  localparam int BW   = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] en_q, ie_q, sinc_q, dinc_q, paced_q, done_q;
  logic              abort_pend;

  dma_state_e        state, state_n;
  logic [CH_W-1:0]   cur, last;
  logic [BW-1:0]     beats;

  logic              sel_glob;
  logic [CH_W-1:0]   rch;
  logic [1:0]        rreg;
  logic [GW-1:0]     gword;
  logic [NUM_CH-1:0] wr_hit;
  logic [31:0]       rd_val;

  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   gidx;
  logic              gvalid;

  logic grant_go, rd_done, wr_done;
  logic adv_fin, adv_abort, adv_cont, abort_clr;

  assign sel_glob = reg_addr[RA_W-1];
  assign rch      = reg_addr[RA_W-2:2];
  assign rreg     = reg_addr[1:0];
  assign gword    = reg_addr[RA_W-2:0];

  always_comb begin
    wr_hit = '0;
    elig   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = reg_en && reg_we && !sel_glob
                  && (rch == CH_W'(i));
      elig[i]   = en_q[i] && (!paced_q[i] || dreq[i]);
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel_glob) begin
      if (gword == GW'(GREG_STATUS))
        rd_val = 32'(done_q);
      else if (gword == GW'(GREG_BUSY))
        rd_val = 32'(en_q);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rch == CH_W'(i)) begin
          unique case (rreg)
            REG_SRC:  rd_val = 32'(src_q[i]);
            REG_DST:  rd_val = 32'(dst_q[i]);
            REG_CNT:  rd_val = 32'(cnt_q[i]);
            default:  rd_val = 32'({paced_q[i], dinc_q[i],
                                    sinc_q[i], ie_q[i],
                                    en_q[i]});
          endcase
        end
      end
    end
  end

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .eligible    (elig),
    .last        (last),
    .grant       (gidx),
    .grant_valid (gvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_go  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    adv_fin   = 1'b0;
    adv_abort = 1'b0;
    adv_cont  = 1'b0;
    abort_clr = 1'b0;
    unique case (state)
      IDLE: begin
        // An abort that landed in the final ADV cycle is retired here
        if (abort_pend) begin
          abort_clr = 1'b1;
        end else if (gvalid) begin
          grant_go = 1'b1;
          state_n  = (cnt_q[gidx] == '0) ? ADV : RD;
        end
      end
      RD: begin
        if (mem_ready) begin
          rd_done = 1'b1;
          state_n = WR;
        end
      end
      WR: begin
        if (mem_ready) begin
          wr_done = 1'b1;
          state_n = ADV;
        end
      end
      ADV: begin
        if (cnt_q[cur] == '0) begin
          adv_fin = 1'b1;
          state_n = IDLE;
        end else if (abort_pend) begin
          adv_abort = 1'b1;
          state_n   = IDLE;
        end else if (beats == BW'(BURST_LEN)
                     || (paced_q[cur] && !dreq[cur])) begin
          state_n = IDLE;
        end else begin
          adv_cont = 1'b1;
          state_n  = RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      en_q       <= '0;
      ie_q       <= '0;
      sinc_q     <= '0;
      dinc_q     <= '0;
      paced_q    <= '0;
      done_q     <= '0;
      abort_pend <= 1'b0;
      cur        <= '0;
      last       <= CH_W'(NUM_CH - 1);
      beats      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dma_irq    <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      // Software writes first; FSM updates below override them
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          unique case (rreg)
            REG_SRC:
              if (!en_q[i]) src_q[i] <= ADDR_W'(reg_wdata);
            REG_DST:
              if (!en_q[i]) dst_q[i] <= ADDR_W'(reg_wdata);
            REG_CNT:
              if (!en_q[i]) cnt_q[i] <= CNT_W'(reg_wdata);
            default: begin
              en_q[i]    <= reg_wdata[CTRL_EN];
              ie_q[i]    <= reg_wdata[CTRL_IE];
              sinc_q[i]  <= reg_wdata[CTRL_SINC];
              dinc_q[i]  <= reg_wdata[CTRL_DINC];
              paced_q[i] <= reg_wdata[CTRL_PACED];
              if (reg_wdata[CTRL_ABORT]) begin
                if (state != IDLE && cur == CH_W'(i))
                  abort_pend <= 1'b1;
                else
                  en_q[i] <= 1'b0;
              end
            end
          endcase
        end
      end

      if (reg_en && reg_we && sel_glob
          && gword == GW'(GREG_STATUS))
        done_q <= done_q & ~reg_wdata[NUM_CH-1:0];

      if (grant_go) begin
        cur   <= gidx;
        last  <= gidx;
        beats <= '0;
        if (cnt_q[gidx] != '0) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= src_q[gidx];
        end
      end

      if (rd_done) begin
        mem_we    <= 1'b1;
        mem_addr  <= dst_q[cur];
        mem_wdata <= mem_rdata;
      end

      if (wr_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (sinc_q[cur]) src_q[cur] <= src_q[cur] + STEP;
        if (dinc_q[cur]) dst_q[cur] <= dst_q[cur] + STEP;
        cnt_q[cur] <= cnt_q[cur] - CNT_W'(1);
        beats      <= beats + BW'(1);
      end

      if (adv_fin) begin
        en_q[cur]   <= 1'b0;
        done_q[cur] <= 1'b1;
      end

      if (adv_abort || abort_clr) begin
        en_q[cur]  <= 1'b0;
        abort_pend <= 1'b0;
      end

      if (adv_cont) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= src_q[cur];
      end

      dma_irq <= |(done_q & ie_q);

      if (reg_en) reg_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_dma_controller_mc.sv
// Directed bench for dma_controller_mc with a simple memory responder.
// Read data is the beat address XOR a fixed tag.
module tb_dma_controller_mc;

  localparam logic [31:0] TAG = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_en, reg_we;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  dreq;
  logic        dma_irq;

  int errs = 0;
  int checks = 0;
  int req_cyc = 0;
  int wr_beats = 0;

  logic [31:0] log_a [$];
  logic        log_w [$];
  logic [31:0] log_d [$];

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ TAG;

  dma_controller_mc dut (
    .clk       (clk),
    .rst       (rst),
    .reg_en    (reg_en),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dreq      (dreq),
    .dma_irq   (dma_irq)
  );

  always @(posedge clk) begin
    if (!rst && mem_req) req_cyc++;
    if (!rst && mem_req && mem_ready) begin
      log_a.push_back(mem_addr);
      log_w.push_back(mem_we);
      log_d.push_back(mem_wdata);
      if (mem_we) wr_beats++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ca(input int ch, input int r);
    logic [2:0] c;
    logic [1:0] rr;
    c  = 3'(ch);
    rr = 2'(r);
    return {1'b0, c, rr};
  endfunction

  function automatic logic [5:0] ga(input int w);
    return 6'b100000 | 6'(w);
  endfunction

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b1;
    reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    @(negedge clk);
    reg_en = 1'b0;
    d = reg_rdata;
  endtask

  task automatic clr_log();
    log_a.delete();
    log_w.delete();
    log_d.delete();
    wr_beats = 0;
  endtask

  task automatic setup(input int ch, input logic [31:0] s,
                       input logic [31:0] d, input logic [31:0] n);
    wr(ca(ch, 0), s);
    wr(ca(ch, 1), d);
    wr(ca(ch, 2), n);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] wq [$];
    logic [31:0] e;
    int base, bad, found;

    rst = 1'b1; reg_en = 1'b0; reg_we = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    mem_ready = 1'b1; dreq = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_irq", 32'(dma_irq), 0);
    chk("rst_rdata", reg_rdata, 0);
    rd(ga(1), v); chk("rst_busy", v, 0);

    // basic 3-beat copy with IRQ
    clr_log();
    setup(0, 32'h100, 32'h200, 3);
    wr(ca(0, 3), 32'h0F);
    repeat (30) @(negedge clk);
    chk("t1_beats", log_a.size(), 6);
    for (int k = 0; k < 3; k++) begin
      chk("t1_raddr", log_a[2*k], 32'h100 + 4*k);
      chk("t1_rwe", 32'(log_w[2*k]), 0);
      chk("t1_waddr", log_a[2*k+1], 32'h200 + 4*k);
      chk("t1_wwe", 32'(log_w[2*k+1]), 1);
      chk("t1_wdata", log_d[2*k+1], (32'h100 + 4*k) ^ TAG);
    end
    chk("t1_irq", 32'(dma_irq), 1);
    rd(ca(0, 3), v); chk("t1_ctrl", v, 32'h0E);
    rd(ga(0), v); chk("t1_status", v, 32'h1);
    rd(ca(0, 2), v); chk("t1_cnt", v, 0);
    wr(ga(0), 32'h1);
    @(negedge clk);
    chk("t1_irq_clr", 32'(dma_irq), 0);

    // fixed source, incrementing destination
    clr_log();
    setup(1, 32'h300, 32'h400, 2);
    wr(ca(1, 3), 32'h09);
    repeat (30) @(negedge clk);
    chk("t2_beats", log_a.size(), 4);
    chk("t2_r0", log_a[0], 32'h300);
    chk("t2_w0", log_a[1], 32'h400);
    chk("t2_r1", log_a[2], 32'h300);
    chk("t2_w1", log_a[3], 32'h404);

    // zero-count channel finishes with no bus traffic
    base = req_cyc;
    wr(ca(2, 2), 0);
    wr(ca(2, 3), 32'h01);
    repeat (10) @(negedge clk);
    chk("t2_zero_req", req_cyc - base, 0);
    rd(ga(0), v); chk("t2_status", v, 32'h6);
    chk("t2_irq", 32'(dma_irq), 0);
    rd(ca(2, 3), v); chk("t2_ctrl2", v, 0);

    // two channels interleaving in bursts
    wr(ga(0), 32'h6);
    clr_log();
    setup(3, 32'h3000, 32'h4000, 8);
    setup(0, 32'h1000, 32'h2000, 8);
    wr(ca(0, 3), 32'h0D);
    wr(ca(3, 3), 32'h0D);
    repeat (120) @(negedge clk);
    wq.delete();
    for (int i = 0; i < log_a.size(); i++)
      if (log_w[i]) wq.push_back(log_a[i]);
    chk("t3_writes", wq.size(), 16);
    for (int b = 0; b < 16; b++) begin
      e = (((b / 4) % 2 == 0) ? 32'h2000 : 32'h4000)
          + 32'((b / 8) * 16) + 32'((b % 4) * 4);
      chk("t3_order", (b < wq.size()) ? wq[b] : 32'hX, e);
    end
    rd(ga(0), v); chk("t3_status", v, 32'h9);

    // paced channel stalls when dreq drops
    wr(ga(0), 32'h9);
    clr_log();
    dreq[4] = 1'b1;
    setup(4, 32'h500, 32'h600, 4);
    wr(ca(4, 3), 32'h1D);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      if (wr_beats >= 2) found = 1;
    end
    chk("t4_two_beats", found, 1);
    dreq[4] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_stall_req", 32'(mem_req), 0);
    chk("t4_stall_wr", wr_beats, 2);
    rd(ca(4, 2), v); chk("t4_cnt", v, 2);
    dreq[4] = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_resume_wr", wr_beats, 4);
    rd(ga(0), v); chk("t4_status", v, 32'h10);
    rd(ga(1), v); chk("t4_busy", v, 0);

    // memory stall, with abort during the wait
    wr(ga(0), 32'h10);
    clr_log();
    mem_ready = 1'b0;
    setup(5, 32'h700, 32'h800, 4);
    wr(ca(5, 3), 32'h0D);
    @(negedge clk);
    chk("t5_req", 32'(mem_req), 1);
    chk("t5_addr", mem_addr, 32'h700);
    chk("t5_we", 32'(mem_we), 0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== 32'h700
          || mem_we !== 1'b0) bad++;
    end
    chk("t5_stable", bad, 0);
    wr(ca(5, 3), 32'h2D);
    chk("t5_hold_req", 32'(mem_req), 1);
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_beats", log_a.size(), 2);
    chk("t5_waddr", log_a[1], 32'h800);
    rd(ca(5, 3), v); chk("t5_ctrl", v, 32'h0C);
    rd(ga(0), v); chk("t5_status", v, 0);
    rd(ca(5, 2), v); chk("t5_cnt", v, 3);

    // reset in the middle of a write beat
    wr(ca(7, 3), 32'h03);
    repeat (5) @(negedge clk);
    chk("t6_irq_pre", 32'(dma_irq), 1);
    mem_ready = 1'b0;
    setup(6, 32'h900, 32'hA00, 2);
    wr(ca(6, 3), 32'h0D);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("t6_in_wr", 32'(mem_we), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_req", 32'(mem_req), 0);
    chk("t6_we", 32'(mem_we), 0);
    chk("t6_irq", 32'(dma_irq), 0);
    rst = 1'b0;
    rd(ga(0), v); chk("t6_status", v, 0);
    rd(ca(6, 3), v); chk("t6_ctrl", v, 0);
    rd(ca(6, 0), v); chk("t6_src", v, 0);
    rd(ga(1), v); chk("t6_busy", v, 0);
    rd(ca(7, 3), v); chk("t6_ctrl7", v, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
